// File: rtl/hazard_control_unit.sv
// Stall/flush/hold controller for the IF, ID and EX boundaries.
// Optional statistics counters are enabled with HAZARD_STATS_EN.
module hazard_control_unit #(
    parameter int rwidth     = 5,
    parameter int MD_LATENCY = 4,
    parameter int CWIDTH     = 8,
    parameter int SWIDTH     = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [rwidth-1:0] IF_ID_RegisterRs,
    input  logic [rwidth-1:0] IF_ID_RegisterRt,
    input  logic              ID_UsesRt,
    input  logic              ID_IsBranch,
    input  logic              ID_Branch_Taken,
    input  logic              EX_MemRead,
    input  logic              EX_RegWrite,
    input  logic [rwidth-1:0] EX_WriteReg,
    input  logic              EX_MulDiv_Start,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Flush,
    output logic              EX_Hold,
    output logic [SWIDTH-1:0] Stall_Cycles,
    output logic [SWIDTH-1:0] Flush_Count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL1  = 2'd1,
        MD_BUSY = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CWIDTH-1:0] cnt, cnt_nxt;
    logic              match, lu, br;

    assign match = (EX_WriteReg != '0) &&
                   ((EX_WriteReg == IF_ID_RegisterRs) ||
                    (ID_UsesRt && (EX_WriteReg == IF_ID_RegisterRt)));
    assign lu = EX_MemRead && match;
    assign br = ID_IsBranch && EX_RegWrite && !EX_MemRead && match;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        EX_Hold     = 1'b0;
        state_nxt   = RUN;
        cnt_nxt     = cnt;
        if (!Reset_n) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            cnt_nxt     = '0;
        end else begin
            case (state)
                RUN: begin
                    if (EX_MulDiv_Start) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        EX_Hold     = 1'b1;
                        cnt_nxt     = CWIDTH'(MD_LATENCY - 2);
                        state_nxt   = MD_BUSY;
                    end else if (lu || br) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                        // a load feeding a branch needs a second bubble
                        if (lu && ID_IsBranch)
                            state_nxt = STALL1;
                    end else begin
                        IF_ID_Flush = ID_Branch_Taken;
                    end
                end
                STALL1: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
                MD_BUSY: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    EX_Hold     = 1'b1;
                    if (cnt == CWIDTH'(1)) begin
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt   = cnt - CWIDTH'(1);
                        state_nxt = MD_BUSY;
                    end
                end
                default: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                    cnt_nxt     = '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [SWIDTH-1:0] stall_q, flush_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PC_Write && (stall_q != '1))
                stall_q <= stall_q + SWIDTH'(1);
            if (IF_ID_Flush && (flush_q != '1))
                flush_q <= flush_q + SWIDTH'(1);
        end
    end

    assign Stall_Cycles = stall_q;
    assign Flush_Count  = flush_q;
`else
    assign Stall_Cycles = '0;
    assign Flush_Count  = '0;
`endif

endmodule
